// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state, port id,
// latched command layout and the default highest legal word address.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } cmd_t;

   localparam int unsigned ADDR_MAX_DEFAULT = 126;

   // A word start address is legal when it does not exceed addr_max.
   function automatic logic addr_ok(input logic [15:0] addr, input int unsigned addr_max);
      return ({16'h0000, addr} <= addr_max);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between port A and port B. With a single requester
// that port wins; on a tie the port that was not granted last wins.
// Feeding a constant PORT_B as 'last' turns this into fixed A priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic  a_req,
   input  logic  b_req,
   input  port_t last,
   output port_t winner
);

   // Pick the requester; on a tie alternate away from the last grant.
   always_comb begin
      winner = PORT_A;
      if (a_req && b_req) begin
         winner = (last == PORT_A) ? PORT_B : PORT_A;
      end else if (b_req) begin
         winner = PORT_B;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a word-wide, byte-addressed data memory.
// IDLE latches the winning command, ISSUE strobes the memory for one
// cycle, RESP pulses the winner's ack (out-of-range addresses skip ISSUE).
// Optional macro MEM_ARB_RR_EN: round-robin tie break with a last-grant
// pointer; when undefined, port A always wins ties and no pointer exists.
//
// Handshake: a requester raises req with a stable command and holds it
// until its ack pulse; the arbiter latches the command at grant, so a
// late drop of req does not cancel the transaction and the losing
// request simply stays pending for a later IDLE cycle.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_MAX = ADDR_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        b_req,
   input  logic        a_we,
   input  logic        b_we,
   input  logic [15:0] a_addr,
   input  logic [15:0] b_addr,
   input  logic [15:0] a_wdata,
   input  logic [15:0] b_wdata,
   output logic        a_ack,
   output logic        b_ack,
   output logic        a_err,
   output logic        b_err,
   output logic [15:0] a_rdata,
   output logic [15:0] b_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy,
   output state_t      dbg_state
);

   state_t      state;
   state_t      state_nxt;
   cmd_t        a_cmd;
   cmd_t        b_cmd;
   cmd_t        win_cmd;
   cmd_t        cmd_q;
   port_t       winner;
   port_t       owner_q;
   port_t       last;
   logic        any_req;
   logic        win_ok;
   logic        oor_q;
   logic        grant;
   logic [15:0] rd_val;

   assign a_cmd   = cmd_t'{we: a_we, addr: a_addr, wdata: a_wdata};
   assign b_cmd   = cmd_t'{we: b_we, addr: b_addr, wdata: b_wdata};
   assign any_req = a_req | b_req;
   assign grant   = (state == IDLE) && any_req;
   assign win_cmd = (winner == PORT_B) ? b_cmd : a_cmd;
   assign win_ok  = addr_ok(win_cmd.addr, ADDR_MAX);

   mem_arb_pick u_pick (
      .a_req  (a_req),
      .b_req  (b_req),
      .last   (last),
      .winner (winner)
   );

`ifdef MEM_ARB_RR_EN
   port_t last_q;

   // Remember the most recent grant so the other port wins the next tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= PORT_B;
      end else if (grant) begin
         last_q <= winner;
      end
   end

   assign last = last_q;
`else
   assign last = PORT_B;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the winner's command, identity and range verdict at grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q   <= '0;
         owner_q <= PORT_A;
         oor_q   <= 1'b0;
      end else if (grant) begin
         cmd_q   <= win_cmd;
         owner_q <= winner;
         oor_q   <= ~win_ok;
      end
   end

   // Next state: out-of-range commands go straight to the response.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = win_ok ? ISSUE : RESP;
            end
         end
         ISSUE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read data is returned only for an in-range read.
   assign rd_val = (!cmd_q.we && !oor_q) ? mem_rdata : 16'h0000;

   // Outputs decoded from state: strobes in ISSUE, winner's ack in RESP.
   always_comb begin
      a_ack     = 1'b0;
      b_ack     = 1'b0;
      a_err     = 1'b0;
      b_err     = 1'b0;
      a_rdata   = 16'h0000;
      b_rdata   = 16'h0000;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      busy      = (state != IDLE);
      dbg_state = state;
      case (state)
         ISSUE: begin
            mem_read  = ~cmd_q.we;
            mem_write = cmd_q.we;
            mem_addr  = cmd_q.addr;
            mem_wdata = cmd_q.wdata;
         end
         RESP: begin
            if (owner_q == PORT_B) begin
               b_ack   = 1'b1;
               b_err   = oor_q;
               b_rdata = rd_val;
            end else begin
               a_ack   = 1'b1;
               a_err   = oor_q;
               a_rdata = rd_val;
            end
         end
         default: begin
         end
      endcase
   end

endmodule
